// File: rtl/uart_ram_pkg.sv
// Shared protocol constants, controller state encoding and helpers for the
// UART-to-RAM command sequencer and its TX pacer.
package uart_ram_pkg;

    localparam logic [7:0] CMD_PING  = 8'h70;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_PING  = 8'h71;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    localparam int unsigned TX_BYTE_CLKS_DEF    = 520;
    localparam int unsigned RX_TIMEOUT_CLKS_DEF = 65535;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_LEN,
        WR_DATA,
        RD_FETCH,
        RD_LATCH,
        TX_PULSE,
        TX_WAIT
    } ctrlState_t;

    // A length byte of zero encodes a full 256-byte transfer.
    function automatic logic [8:0] lenToCount(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_tx_pacer.sv
// Paces bytes to a UART transmitter that has no busy flag: a load pulse emits
// tx_start one clock later and starts a TX_BYTE_CLKS window tracked by done.
module uart_tx_pacer
    import uart_ram_pkg::*;
#(
    parameter int unsigned TX_BYTE_CLKS = TX_BYTE_CLKS_DEF,
    parameter int unsigned LEAD         = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] loadData,
    output logic       txStart,
    output logic [7:0] txData,
    output logic       done,
    output logic       almostDone
);

    localparam int unsigned CNT_W = $clog2(TX_BYTE_CLKS);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    // Counter sits at zero once the byte window has elapsed.
    always_comb begin
        cntNext = cnt;
        if (load) begin
            cntNext = CNT_W'(TX_BYTE_CLKS - 1);
        end else if (cnt != '0) begin
            cntNext = cnt - CNT_W'(1);
        end
    end

    // almostDone lets a caller start a multi-cycle prefetch LEAD clocks early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            txStart    <= 1'b0;
            txData     <= '0;
            done       <= 1'b1;
            almostDone <= 1'b1;
        end else begin
            cnt        <= cntNext;
            txStart    <= load;
            if (load) begin
                txData <= loadData;
            end
            done       <= (cntNext == '0);
            almostDone <= (cntNext <= CNT_W'(LEAD));
        end
    end

endmodule

// File: rtl/uart_ram_cmd_ctrl.sv
// Host command sequencer (PING / WRITE / READ) between a byte UART and a
// 256x8 synchronous RAM. Define UART_RAM_CMD_CSUM_EN for XOR checksum bytes.
module uart_ram_cmd_ctrl
    import uart_ram_pkg::*;
#(
    parameter int unsigned TX_BYTE_CLKS    = TX_BYTE_CLKS_DEF,
    parameter int unsigned RX_TIMEOUT_CLKS = RX_TIMEOUT_CLKS_DEF,
    parameter int unsigned ADDR_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);

    localparam int unsigned TMR_W = $clog2(RX_TIMEOUT_CLKS + 1);

    ctrlState_t        state;
    ctrlState_t        stateNext;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addrNext;
    logic [8:0]        count;
    logic [8:0]        countNext;
    logic              isRead;
    logic              isReadNext;
    logic [TMR_W-1:0]  idleCnt;
    logic [TMR_W-1:0]  idleCntNext;
    logic [ADDR_W-1:0] ramAddrNext;
    logic [7:0]        ramWdataNext;
    logic              ramWeNext;
    logic [7:0]        loadData;
    logic              pacerLoad;
    logic              pacerDone;
    logic              pacerAlmostDone;
    logic              rxTimeout;
`ifdef UART_RAM_CMD_CSUM_EN
    logic [7:0]        csum;
    logic [7:0]        csumNext;
`endif

    assign rxTimeout = (idleCnt == TMR_W'(RX_TIMEOUT_CLKS - 1));
    assign pacerLoad = (stateNext == TX_PULSE);

    uart_tx_pacer #(
        .TX_BYTE_CLKS (TX_BYTE_CLKS),
        .LEAD         (2)
    ) u_pacer (
        .clk        (clk),
        .rst        (rst),
        .load       (pacerLoad),
        .loadData   (loadData),
        .txStart    (tx_start),
        .txData     (tx_data),
        .done       (pacerDone),
        .almostDone (pacerAlmostDone)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A received byte always takes priority over an expiring idle timer.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        stateNext = GET_ADDR;
                    end else begin
                        stateNext = TX_PULSE;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    stateNext = GET_LEN;
                end else if (rxTimeout) begin
                    stateNext = IDLE;
                end
            end
            GET_LEN: begin
                if (rx_valid) begin
                    stateNext = isRead ? RD_FETCH : WR_DATA;
                end else if (rxTimeout) begin
                    stateNext = IDLE;
                end
            end
            WR_DATA: begin
`ifdef UART_RAM_CMD_CSUM_EN
                if (rx_valid && count == 9'd0) begin
                    stateNext = TX_PULSE;
                end else if (!rx_valid && rxTimeout) begin
                    stateNext = IDLE;
                end
`else
                // The ACK waits one clock so it never coincides with the last write.
                if (count == 9'd0) begin
                    stateNext = TX_PULSE;
                end else if (!rx_valid && rxTimeout) begin
                    stateNext = IDLE;
                end
`endif
            end
            RD_FETCH: stateNext = RD_LATCH;
            RD_LATCH: stateNext = TX_PULSE;
            TX_PULSE: stateNext = TX_WAIT;
            TX_WAIT: begin
                // Leave early for the next byte so fetch+latch land exactly on the window edge.
                if (isRead && count > 9'd1 && pacerAlmostDone) begin
                    stateNext = RD_FETCH;
`ifdef UART_RAM_CMD_CSUM_EN
                end else if (isRead && count == 9'd1 && pacerDone) begin
                    stateNext = TX_PULSE;
`endif
                end else if (pacerDone) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        addrNext     = addr;
        countNext    = count;
        isReadNext   = isRead;
        idleCntNext  = '0;
        ramAddrNext  = ram_addr;
        ramWdataNext = ram_wdata;
        ramWeNext    = 1'b0;
        loadData     = RSP_NAK;
`ifdef UART_RAM_CMD_CSUM_EN
        csumNext     = csum;
`endif
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    isReadNext = (rx_data == CMD_READ);
                    loadData   = (rx_data == CMD_PING) ? RSP_PING : RSP_NAK;
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    addrNext = ADDR_W'(rx_data);
`ifdef UART_RAM_CMD_CSUM_EN
                    csumNext = rx_data;
`endif
                end else begin
                    idleCntNext = idleCnt + TMR_W'(1);
                end
            end
            GET_LEN: begin
                if (rx_valid) begin
                    countNext   = lenToCount(rx_data);
                    ramAddrNext = addr;
`ifdef UART_RAM_CMD_CSUM_EN
                    csumNext    = csum ^ rx_data;
`endif
                end else begin
                    idleCntNext = idleCnt + TMR_W'(1);
                end
            end
            WR_DATA: begin
                if (rx_valid && count != 9'd0) begin
                    ramWeNext    = 1'b1;
                    ramAddrNext  = addr;
                    ramWdataNext = rx_data;
                    addrNext     = addr + ADDR_W'(1);
                    countNext    = count - 9'd1;
`ifdef UART_RAM_CMD_CSUM_EN
                    csumNext     = csum ^ rx_data;
`endif
                end else if (!rx_valid) begin
                    idleCntNext = idleCnt + TMR_W'(1);
                end
`ifdef UART_RAM_CMD_CSUM_EN
                if (rx_valid && count == 9'd0) begin
                    loadData = (rx_data == csum) ? RSP_ACK : RSP_NAK;
                end
`else
                if (count == 9'd0) begin
                    loadData = RSP_ACK;
                end
`endif
            end
            RD_LATCH: begin
                loadData = ram_rdata;
`ifdef UART_RAM_CMD_CSUM_EN
                csumNext = csum ^ ram_rdata;
`endif
            end
            TX_WAIT: begin
                if (stateNext == RD_FETCH) begin
                    addrNext    = addr + ADDR_W'(1);
                    ramAddrNext = addr + ADDR_W'(1);
                    countNext   = count - 9'd1;
                end
`ifdef UART_RAM_CMD_CSUM_EN
                if (stateNext == TX_PULSE) begin
                    loadData  = csum;
                    countNext = 9'd0;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            count     <= '0;
            isRead    <= 1'b0;
            idleCnt   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RAM_CMD_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            addr      <= addrNext;
            count     <= countNext;
            isRead    <= isReadNext;
            idleCnt   <= idleCntNext;
            ram_addr  <= ramAddrNext;
            ram_wdata <= ramWdataNext;
            ram_we    <= ramWeNext;
            busy      <= (stateNext != IDLE);
`ifdef UART_RAM_CMD_CSUM_EN
            csum      <= csumNext;
`endif
        end
    end

endmodule
